// File: rtl/jpeg_dct_seq_if.sv
// rtl/jpeg_dct_seq_if.sv - control/strobe bundle between the DCT sequencer and the accelerator datapath
interface jpeg_dct_seq_if #(
  parameter int CNT_W = 16
);
  logic             start_i;
  logic             abort_i;
  logic [5:0]       rd_adr_o;
  logic             dct_en_o;
  logic             dct_mux_sel_o;
  logic             tmem_wr_o;
  logic             tmem_rd_o;
  logic [1:0]       q_sel_o;
  logic             out_we_o;
  logic [4:0]       wr_adr_o;
  logic             busy_o;
  logic             done_o;
  logic             start_lost_o;
  logic [CNT_W-1:0] blk_cnt_o;

  // Sequencer side: takes start/abort, drives every strobe and status.
  modport slave (
    input  start_i, abort_i,
    output rd_adr_o, dct_en_o, dct_mux_sel_o, tmem_wr_o, tmem_rd_o, q_sel_o,
           out_we_o, wr_adr_o, busy_o, done_o, start_lost_o, blk_cnt_o
  );

  // Controller side (CSR/DMA): issues start/abort, observes status.
  modport master (
    output start_i, abort_i,
    input  rd_adr_o, dct_en_o, dct_mux_sel_o, tmem_wr_o, tmem_rd_o, q_sel_o,
           out_we_o, wr_adr_o, busy_o, done_o, start_lost_o, blk_cnt_o
  );
endinterface

// File: rtl/jpeg_dct_seq.sv
// rtl/jpeg_dct_seq.sv - 8x8 2-D DCT sequencer: row pass into transpose memory, column pass out through the quantiser
module jpeg_dct_seq #(
  parameter int DCT_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  jpeg_dct_seq_if.slave  bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_R_RD0, S_R_RD1, S_R_DCT, S_R_WAIT, S_R_TWR,
    S_C_TRD, S_C_DCT, S_C_WAIT, S_C_WR, S_DONE
  } state_t;

  localparam logic [1:0] LAT_M1 = 2'(DCT_LAT - 1);

  state_t           state_q, state_d;
  logic [2:0]       r_q, r_d;
  logic [2:0]       c_q, c_d;
  logic [1:0]       k_q, k_d;
  logic [1:0]       w_q, w_d;

  logic [5:0]       rd_adr_q;
  logic [4:0]       wr_adr_q;
  logic             dct_en_q, mux_sel_q, tmem_wr_q, tmem_rd_q, out_we_q;
  logic [1:0]       q_sel_q;
  logic             busy_q, done_q, start_lost_q;
  logic [CNT_W-1:0] cnt_q;

  // Next-state and loop-index logic; abort from any active state beats everything else.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    k_d     = k_q;
    w_d     = w_q;
    if (state_q != S_IDLE && bus.abort_i) begin
      state_d = S_IDLE;
      r_d     = 3'd0;
      c_d     = 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start_i) begin
            state_d = S_R_RD0;
            r_d     = 3'd0;
            c_d     = 3'd0;
          end
        end
        S_R_RD0: state_d = S_R_RD1;
        S_R_RD1: state_d = S_R_DCT;
        S_R_DCT: begin
          state_d = S_R_WAIT;
          w_d     = 2'd0;
        end
        S_R_WAIT: begin
          if (w_q == LAT_M1) state_d = S_R_TWR;
          else               w_d     = w_q + 2'd1;
        end
        S_R_TWR: begin
          if (r_q == 3'd7) begin
            state_d = S_C_TRD;
            c_d     = 3'd0;
          end else begin
            state_d = S_R_RD0;
            r_d     = r_q + 3'd1;
          end
        end
        S_C_TRD: state_d = S_C_DCT;
        S_C_DCT: begin
          state_d = S_C_WAIT;
          w_d     = 2'd0;
        end
        S_C_WAIT: begin
          if (w_q == LAT_M1) begin
            state_d = S_C_WR;
            k_d     = 2'd0;
          end else begin
            w_d     = w_q + 2'd1;
          end
        end
        S_C_WR: begin
          if (k_q == 2'd3) begin
            if (c_q == 3'd7) begin
              state_d = S_DONE;
            end else begin
              state_d = S_C_TRD;
              c_d     = c_q + 3'd1;
            end
          end else begin
            k_d = k_q + 2'd1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State register plus all outputs, registered from the next state so nothing is combinational from inputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      r_q          <= 3'd0;
      c_q          <= 3'd0;
      k_q          <= 2'd0;
      w_q          <= 2'd0;
      rd_adr_q     <= 6'd0;
      wr_adr_q     <= 5'd0;
      dct_en_q     <= 1'b0;
      mux_sel_q    <= 1'b0;
      tmem_wr_q    <= 1'b0;
      tmem_rd_q    <= 1'b0;
      out_we_q     <= 1'b0;
      q_sel_q      <= 2'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      start_lost_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      r_q          <= r_d;
      c_q          <= c_d;
      k_q          <= k_d;
      w_q          <= w_d;
      dct_en_q     <= (state_d == S_R_DCT) || (state_d == S_C_DCT);
      mux_sel_q    <= (state_d == S_C_TRD) || (state_d == S_C_DCT);
      tmem_wr_q    <= (state_d == S_R_TWR);
      tmem_rd_q    <= (state_d == S_C_TRD);
      out_we_q     <= (state_d == S_C_WR);
      q_sel_q      <= (state_d == S_C_WR) ? k_d : 2'd0;
      busy_q       <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q       <= (state_d == S_DONE);
      // busy_q mirrors the current state, so this flags starts that arrive mid-block
      start_lost_q <= bus.start_i && busy_q;
      // addresses hold between their own states
      if (state_d == S_R_RD0) rd_adr_q <= {2'b00, r_d, 1'b0};
      if (state_d == S_R_RD1) rd_adr_q <= {2'b00, r_d, 1'b1};
      if (state_d == S_C_WR)  wr_adr_q <= {c_d, k_d};
      // counted on entry to DONE so the new value is visible alongside done_o
      if (state_d == S_DONE && state_q != S_DONE) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.rd_adr_o      = rd_adr_q;
  assign bus.wr_adr_o      = wr_adr_q;
  assign bus.dct_en_o      = dct_en_q;
  assign bus.dct_mux_sel_o = mux_sel_q;
  assign bus.tmem_wr_o     = tmem_wr_q;
  assign bus.tmem_rd_o     = tmem_rd_q;
  assign bus.out_we_o      = out_we_q;
  assign bus.q_sel_o       = q_sel_q;
  assign bus.busy_o        = busy_q;
  assign bus.done_o        = done_q;
  assign bus.start_lost_o  = start_lost_q;
  assign bus.blk_cnt_o     = cnt_q;

endmodule

// File: tb/tb_jpeg_dct_seq.sv
// tb/tb_jpeg_dct_seq.sv - directed table-driven bench for the DCT sequencer
module tb_jpeg_dct_seq;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;

  always #5 clk_i = ~clk_i;

  jpeg_dct_seq_if #(.CNT_W(16)) ifa ();
  jpeg_dct_seq_if #(.CNT_W(2))  ifb ();

  jpeg_dct_seq #(.DCT_LAT(1), .CNT_W(16)) dut_a (.clk_i(clk_i), .rst_ni(rst_ni), .bus(ifa));
  jpeg_dct_seq #(.DCT_LAT(3), .CNT_W(2))  dut_b (.clk_i(clk_i), .rst_ni(rst_ni), .bus(ifb));

  typedef struct {
    string name;
    int    lost1;      // cycle to pulse start_i while busy (-1 none)
    int    lost2;
    int    abort_at;   // cycle to pulse abort_i (-1 none)
    int    exp_done;
    int    exp_lost;
    int    exp_delta;
    int    exp_len;    // cycle at which done_o is seen
  } vec_t;

  vec_t vecs[4];
  int   n_vec = 0;
  int   n_bad = 0;
  int   exp_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"},     int'(ifa.busy_o), 0);
    check({tag, " done"},     int'(ifa.done_o), 0);
    check({tag, " dct_en"},   int'(ifa.dct_en_o), 0);
    check({tag, " mux_sel"},  int'(ifa.dct_mux_sel_o), 0);
    check({tag, " tmem_wr"},  int'(ifa.tmem_wr_o), 0);
    check({tag, " tmem_rd"},  int'(ifa.tmem_rd_o), 0);
    check({tag, " q_sel"},    int'(ifa.q_sel_o), 0);
    check({tag, " out_we"},   int'(ifa.out_we_o), 0);
    check({tag, " rd_adr"},   int'(ifa.rd_adr_o), 0);
    check({tag, " wr_adr"},   int'(ifa.wr_adr_o), 0);
    check({tag, " lost"},     int'(ifa.start_lost_o), 0);
    check({tag, " blk_cnt"},  int'(ifa.blk_cnt_o), 0);
  endtask

  // One block on instance A; the expected row/column schedule is rebuilt from cycle numbers.
  task automatic run_vec(input vec_t v);
    int n_done = 0, n_lost = 0, done_at = -1;
    int n_dct = 0, n_tw = 0, n_tr = 0, n_we = 0;
    int bad_rd = 0, bad_wr = 0, bad_busy = 0, bad_abort = 0;
    int r, c, ph, k;
    @(negedge clk_i);
    ifa.start_i = 1'b1;
    @(negedge clk_i);
    ifa.start_i = 1'b0;
    for (int cyc = 1; cyc <= 130; cyc++) begin
      if (cyc == 1 && ifa.busy_o !== 1'b1) bad_busy++;
      if (ifa.done_o) begin
        n_done++;
        if (done_at < 0) done_at = cyc;
      end
      n_lost += int'(ifa.start_lost_o);
      n_dct  += int'(ifa.dct_en_o);
      n_tw   += int'(ifa.tmem_wr_o);
      n_tr   += int'(ifa.tmem_rd_o);
      n_we   += int'(ifa.out_we_o);
      if (v.abort_at < 0) begin
        if (cyc <= 40) begin
          r  = (cyc - 1) / 5;
          ph = (cyc - 1) % 5;
          if (ph == 0 && int'(ifa.rd_adr_o) != 2 * r)     bad_rd++;
          if (ph == 1 && int'(ifa.rd_adr_o) != 2 * r + 1) bad_rd++;
          if (ph == 2 && (!ifa.dct_en_o || ifa.dct_mux_sel_o)) bad_rd++;
          if (ph == 4 && !ifa.tmem_wr_o) bad_rd++;
        end else if (cyc <= 96) begin
          c  = (cyc - 41) / 7;
          ph = (cyc - 41) % 7;
          if (ph >= 3) begin
            k = ph - 3;
            if (!ifa.out_we_o || int'(ifa.wr_adr_o) != 4 * c + k || int'(ifa.q_sel_o) != k) bad_wr++;
          end else begin
            if (ifa.out_we_o) bad_wr++;
            if (ph == 0 && !(ifa.tmem_rd_o && ifa.dct_mux_sel_o)) bad_wr++;
            if (ph == 1 && !(ifa.dct_en_o && ifa.dct_mux_sel_o)) bad_wr++;
          end
        end else if (cyc > 97 && ifa.busy_o) begin
          bad_busy++;
        end
      end else if (cyc == v.abort_at + 1 && ifa.busy_o !== 1'b0) begin
        bad_abort++;
      end
      ifa.start_i = (cyc == v.lost1 || cyc == v.lost2);
      ifa.abort_i = (cyc == v.abort_at);
      @(negedge clk_i);
    end
    ifa.start_i = 1'b0;
    ifa.abort_i = 1'b0;
    exp_cnt = (exp_cnt + v.exp_delta) & 32'hFFFF;
    check({v.name, " done count"}, n_done, v.exp_done);
    check({v.name, " start_lost count"}, n_lost, v.exp_lost);
    check({v.name, " blk_cnt"}, int'(ifa.blk_cnt_o), exp_cnt);
    check({v.name, " busy timing"}, bad_busy, 0);
    if (v.exp_done > 0) check({v.name, " latency"}, done_at, v.exp_len);
    if (v.abort_at < 0) begin
      check({v.name, " dct_en count"}, n_dct, 16);
      check({v.name, " tmem_wr count"}, n_tw, 8);
      check({v.name, " tmem_rd count"}, n_tr, 8);
      check({v.name, " out_we count"}, n_we, 32);
      check({v.name, " row schedule"}, bad_rd, 0);
      check({v.name, " column schedule"}, bad_wr, 0);
    end else begin
      check({v.name, " busy after abort"}, bad_abort, 0);
    end
  endtask

  initial begin
    int idle_act, cyc;
    vecs[0] = '{"plain",   -1, -1, -1, 1, 0, 1, 97};
    vecs[1] = '{"lost",    10, 50, -1, 1, 2, 1, 97};
    vecs[2] = '{"abort",   -1, -1, 60, 0, 0, 0, 0};
    vecs[3] = '{"restart", -1, -1, -1, 1, 0, 1, 97};

    ifa.start_i = 1'b0;
    ifa.abort_i = 1'b0;
    ifb.start_i = 1'b0;
    ifb.abort_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check_all_zero("reset");
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    check("idle after release", int'(ifa.busy_o), 0);

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // reset in the middle of a row pass must clear everything without waiting for a clock
    @(negedge clk_i);
    ifa.start_i = 1'b1;
    @(negedge clk_i);
    ifa.start_i = 1'b0;
    repeat (29) @(negedge clk_i);
    check("busy before mid reset", int'(ifa.busy_o), 1);
    #2 rst_ni = 1'b0;
    #1;
    check_all_zero("mid reset");
    exp_cnt = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle_act = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      idle_act += int'(ifa.busy_o) + int'(ifa.dct_en_o) + int'(ifa.out_we_o) + int'(ifa.done_o);
    end
    check("idle after mid reset", idle_act, 0);
    run_vec(vecs[0]);

    // longer DCT latency and a narrow counter that wraps on the fourth block
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      ifb.start_i = 1'b1;
      @(negedge clk_i);
      ifb.start_i = 1'b0;
      cyc = 1;
      while (!ifb.done_o && cyc < 300) begin
        @(negedge clk_i);
        cyc++;
      end
      check($sformatf("lat3 block %0d latency", i), cyc, 97 + 16 * 2);
      check($sformatf("lat3 block %0d blk_cnt", i), int'(ifb.blk_cnt_o), (i + 1) % 4);
      @(negedge clk_i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
